// File: rtl/usb_tx_pkg.sv
// Shared types for the USB transmit path: packet kinds, scheduler states,
// and a helper that sizes the shared gap/timeout counter.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        PKT_NONE = 2'd0,
        PKT_ACK  = 2'd1,
        PKT_NAK  = 2'd2,
        PKT_DATA = 2'd3
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    // Request sources, indexed ack=0, nak=1, data=2 (pkt_t value minus one)
    localparam int NUM_REQ = 3;

    // Counter width able to hold max(a,b)-1
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/usb_tx_gap_timer.sv
// Loadable down-counter with zero flag. The scheduler reuses one instance for
// the inter-packet gap and, when enabled, the transmit timeout.
module usb_tx_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/usb_tx_scheduler.sv
// USB transmit scheduler: latches ACK/NAK/DATA requests, arbitrates them with
// fixed priority ACK > NAK > DATA, issues one strobe per packet, waits for
// tx_done and then enforces an inter-packet gap.
// Optional feature: define USB_TX_SCHED_TIMEOUT_EN to abandon a packet when
// tx_done does not arrive within TIMEOUT_CYCLES clocks of the strobe.
module usb_tx_scheduler
    import usb_tx_pkg::*;
#(
    parameter int IPG_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ack_req,
    input  logic       nak_req,
    input  logic       data_req,
    input  logic       fifo_empty,
    input  logic       tx_done,
    output logic       tx_send_good,
    output logic       tx_send_bad,
    output logic       tx_transmit,
    output logic       tx_busy,
    output logic [1:0] grant,
    output logic       tx_timeout
);

    localparam int TMR_W = cnt_width(IPG_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] IPG_LOAD = TMR_W'(IPG_CYCLES - 1);
`ifdef USB_TX_SCHED_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

    sched_state_t       state_reg, state_next;
    pkt_t               grant_reg, grant_next;
    pkt_t               sel;
    logic               grant_now;
    logic [NUM_REQ-1:0] req_vec, raw_req, pend_reg, pend_next;
    logic               send_good_reg, send_good_next;
    logic               send_bad_reg, send_bad_next;
    logic               transmit_reg, transmit_next;
    logic               busy_reg, busy_next;
    logic               timeout_reg, timeout_next;
    logic               tmr_load, tmr_dec, tmr_zero, gap_last;
    logic [TMR_W-1:0]   tmr_load_val, tmr_count;

    assign req_vec = {data_req, nak_req, ack_req};

    // A request counts as soon as it is seen; a pending flag is dropped only
    // when that type wins arbitration, so repeats while busy merge into one.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pend
            assign raw_req[gi]   = pend_reg[gi] | req_vec[gi];
            assign pend_next[gi] = raw_req[gi] & ~(grant_now && (sel == pkt_t'(2'(gi + 1))));
        end
    endgenerate

    // Fixed-priority arbiter; DATA only competes when the FIFO has something
    always_comb begin
        sel = PKT_NONE;
        if (raw_req[0]) begin
            sel = PKT_ACK;
        end else if (raw_req[1]) begin
            sel = PKT_NAK;
        end else if (raw_req[2] && !fifo_empty) begin
            sel = PKT_DATA;
        end
    end

    assign grant_now = (state_reg == IDLE) && (sel != PKT_NONE);
    // Gap ends on the clock that takes the counter down to zero
    assign gap_last  = tmr_zero || (tmr_count == TMR_W'(1));

    usb_tx_gap_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // State, pending flags and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= PKT_NONE;
            pend_reg      <= '0;
            send_good_reg <= 1'b0;
            send_bad_reg  <= 1'b0;
            transmit_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            pend_reg      <= pend_next;
            send_good_reg <= send_good_next;
            send_bad_reg  <= send_bad_next;
            transmit_reg  <= transmit_next;
            busy_reg      <= busy_next;
            timeout_reg   <= timeout_next;
        end
    end

    // Next-state logic and timer control
    always_comb begin
        state_next   = state_reg;
        tmr_load     = 1'b0;
        tmr_load_val = IPG_LOAD;
        tmr_dec      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel != PKT_NONE) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = ACTIVE;
`ifdef USB_TX_SCHED_TIMEOUT_EN
                tmr_load     = 1'b1;
                tmr_load_val = TMO_LOAD;
`endif
            end
            ACTIVE: begin
                if (tx_done) begin
                    state_next = GAP;
                    tmr_load   = 1'b1;
`ifdef USB_TX_SCHED_TIMEOUT_EN
                end else if (tmr_zero) begin
                    // Give up on this packet; it is not retried
                    state_next = GAP;
                    tmr_load   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
`endif
                end
            end
            GAP: begin
                tmr_dec = 1'b1;
                if (gap_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        send_good_next = (state_reg == ISSUE) && (grant_reg == PKT_ACK);
        send_bad_next  = (state_reg == ISSUE) && (grant_reg == PKT_NAK);
        transmit_next  = (state_reg == ISSUE) && (grant_reg == PKT_DATA);
        busy_next      = (state_next == ACTIVE) || (state_next == GAP);
        grant_next     = grant_reg;
        if (grant_now) begin
            grant_next = sel;
        end else if ((state_reg == GAP) && gap_last) begin
            grant_next = PKT_NONE;
        end
        timeout_next = 1'b0;
`ifdef USB_TX_SCHED_TIMEOUT_EN
        timeout_next = (state_reg == ACTIVE) && !tx_done && tmr_zero;
`endif
    end

    assign tx_send_good = send_good_reg;
    assign tx_send_bad  = send_bad_reg;
    assign tx_transmit  = transmit_reg;
    assign tx_busy      = busy_reg;
    assign grant        = grant_reg;
    assign tx_timeout   = timeout_reg;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Testbench for usb_tx_scheduler. Stimulus pushes the expected strobe kind and
// cycle into a scoreboard queue; a monitor pops and compares on every strobe.
// A small transmitter model answers each strobe with tx_done after resp_delay.
`timescale 1ns/1ps
module tb_usb_tx_scheduler;
    import usb_tx_pkg::*;

    localparam int IPG = 4;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack_req = 1'b0, nak_req = 1'b0, data_req = 1'b0;
    logic       fifo_empty = 1'b1, tx_done = 1'b0;
    logic       tx_send_good, tx_send_bad, tx_transmit, tx_busy, tx_timeout;
    logic [1:0] grant;

    usb_tx_scheduler #(
        .IPG_CYCLES     (IPG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ack_req      (ack_req),
        .nak_req      (nak_req),
        .data_req     (data_req),
        .fifo_empty   (fifo_empty),
        .tx_done      (tx_done),
        .tx_send_good (tx_send_good),
        .tx_send_bad  (tx_send_bad),
        .tx_transmit  (tx_transmit),
        .tx_busy      (tx_busy),
        .grant        (grant),
        .tx_timeout   (tx_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        pkt_t kind;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_done = -1000;
    int   n_tests = 0;
    int   n_fail = 0;
    int   resp_delay = 0;
    int   dn = 0;
    int   mon_ns;
    pkt_t mon_kind;
    exp_t mon_e;
    int   c, s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pkt(input pkt_t k, input int cy);
        exp_t e;
        e.kind = k;
        e.cyc  = cy;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic until_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Cycle counter; remembers the cycle in which tx_done was presented
    always @(posedge clk) begin
        if (tx_done) last_done <= cyc;
        cyc <= cyc + 1;
    end

    // Transmitter model: tx_done for one cycle, resp_delay cycles after a strobe
    always @(negedge clk) begin
        if (rst) begin
            dn      = 0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (dn > 0) begin
                dn--;
                if (dn == 0) tx_done = 1'b1;
            end
            if ((tx_send_good | tx_send_bad | tx_transmit) && resp_delay > 0) dn = resp_delay;
        end
    end

    // Monitor: every strobe is matched against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            mon_ns = int'(tx_send_good) + int'(tx_send_bad) + int'(tx_transmit);
            if (mon_ns > 1) begin
                chk("strobe_exclusive", mon_ns, 1);
            end else if (mon_ns == 1) begin
                mon_kind = tx_send_good ? PKT_ACK : (tx_send_bad ? PKT_NAK : PKT_DATA);
                $display("[TB] cycle %0d strobe %s", cyc, mon_kind.name());
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", mon_kind, PKT_NONE);
                end else begin
                    mon_e = sb.pop_front();
                    chk("strobe_kind", mon_kind, mon_e.kind);
                    chk("strobe_cycle", cyc, mon_e.cyc);
                end
                chk("grant_at_strobe", grant, mon_kind);
                chk("busy_at_strobe", tx_busy, 1'b1);
                chk("ipg_respected", (cyc - last_done) > IPG, 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        chk("rst_good", tx_send_good, 0);
        chk("rst_bad", tx_send_bad, 0);
        chk("rst_xmit", tx_transmit, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_grant", grant, PKT_NONE);
        chk("rst_timeout", tx_timeout, 0);
        rst = 1'b0;
        step(2);

        // Single ACK: strobe two cycles after request, busy drops 4 after tx_done
        resp_delay = 20;
        c = cyc;
        s = c + 2;
        ack_req = 1'b1;
        expect_pkt(PKT_ACK, s);
        step(1);
        ack_req = 1'b0;
        until_cyc(s + 1);
        chk("ack_strobe_one_cycle", tx_send_good, 0);
        until_cyc(s + 23);
        chk("busy_before_gap_end", tx_busy, 1);
        until_cyc(s + 24);
        chk("busy_after_gap", tx_busy, 0);
        chk("grant_after_gap", grant, PKT_NONE);
        step(4);
        chk("t2_drained", sb.size(), 0);

        // All three together: ACK, NAK, DATA in priority order
        fifo_empty = 1'b0;
        c = cyc;
        ack_req = 1'b1; nak_req = 1'b1; data_req = 1'b1;
        expect_pkt(PKT_ACK, c + 2);
        expect_pkt(PKT_NAK, c + 28);
        expect_pkt(PKT_DATA, c + 54);
        step(1);
        ack_req = 1'b0; nak_req = 1'b0; data_req = 1'b0;
        until_cyc(c + 82);
        chk("t3_drained", sb.size(), 0);

        // DATA held while FIFO empty, sent once it fills
        fifo_empty = 1'b1;
        resp_delay = 5;
        data_req = 1'b1;
        step(1);
        data_req = 1'b0;
        step(100);
        chk("empty_fifo_idle_busy", tx_busy, 0);
        chk("empty_fifo_idle_grant", grant, PKT_NONE);
        c = cyc;
        fifo_empty = 1'b0;
        expect_pkt(PKT_DATA, c + 2);
        until_cyc(c + 16);
        chk("t4_drained", sb.size(), 0);

        // NAK arriving during DATA waits for DATA completion plus gap
        resp_delay = 10;
        c = cyc;
        data_req = 1'b1;
        expect_pkt(PKT_DATA, c + 2);
        step(1);
        data_req = 1'b0;
        until_cyc(c + 5);
        chk("data_in_flight", grant, PKT_DATA);
        nak_req = 1'b1;
        expect_pkt(PKT_NAK, c + 18);
        step(1);
        nak_req = 1'b0;
        until_cyc(c + 36);
        chk("t5_drained", sb.size(), 0);

        // No tx_done at all
        resp_delay = 0;
        c = cyc;
        s = c + 2;
        ack_req = 1'b1;
        expect_pkt(PKT_ACK, s);
        step(1);
        ack_req = 1'b0;
`ifdef USB_TX_SCHED_TIMEOUT_EN
        until_cyc(s + 63);
        chk("timeout_not_early", tx_timeout, 0);
        until_cyc(s + 64);
        chk("timeout_pulse", tx_timeout, 1);
        until_cyc(s + 65);
        chk("timeout_one_cycle", tx_timeout, 0);
        until_cyc(s + 66);
        chk("timeout_gap_busy", tx_busy, 1);
        until_cyc(s + 67);
        chk("timeout_then_idle", tx_busy, 0);
        chk("timeout_grant_none", grant, PKT_NONE);
        step(5);
`else
        until_cyc(s + 80);
        chk("no_timeout_flag", tx_timeout, 0);
        chk("no_timeout_busy", tx_busy, 1);
        chk("no_timeout_grant", grant, PKT_ACK);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
`endif
        chk("t6_drained", sb.size(), 0);

        // Reset in the middle of a packet drops everything pending
        c = cyc;
        ack_req = 1'b1;
        expect_pkt(PKT_ACK, c + 2);
        step(1);
        ack_req = 1'b0;
        until_cyc(c + 6);
        nak_req = 1'b1; data_req = 1'b1;
        step(1);
        nak_req = 1'b0; data_req = 1'b0;
        until_cyc(c + 9);
        chk("pre_reset_busy", tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_grant", grant, PKT_NONE);
        chk("midrst_strobes", {tx_send_good, tx_send_bad, tx_transmit, tx_timeout}, 0);
        step(1);
        rst = 1'b0;
        step(20);
        chk("pending_cleared_busy", tx_busy, 0);
        chk("t1_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
